// File: rtl/ysyx_24100029_pkg.sv
// Shared constants for the IDU->EXU pipeline slice.
// Forwarding select encodings and default datapath widths.
package ysyx_24100029_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int CTRL_W_DEFAULT = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXU = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ysyx_24100029_fwd_mux.sv
// Combinational 3-way source operand select.
// Reserved select code 2'b11 falls back to the register file.
module ysyx_24100029_fwd_mux
    import ysyx_24100029_pkg::*;
#(
    parameter int W = XLEN_DEFAULT
) (
    input  logic [1:0]   choice,
    input  logic [W-1:0] rf_data,
    input  logic [W-1:0] exu_data,
    input  logic [W-1:0] mem_data,
    output logic [W-1:0] src
);

    always_comb begin
        src = rf_data;
        unique case (1'b1)
            (choice == FWD_EXU): src = exu_data;
            (choice == FWD_MEM): src = mem_data;
            default:             src = rf_data;
        endcase
    end

endmodule

// File: rtl/ysyx_24100029_idu_exu_pipe.sv
// ID->EX pipeline register with operand forwarding and load-use stall.
// Define YSYX_24100029_PIPE_PERF_EN to add saturating perf counters.
module ysyx_24100029_idu_exu_pipe
    import ysyx_24100029_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rd,
    input  logic              in_r_wen,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic [1:0]        rs1_choice,
    input  logic [1:0]        rs2_choice,
    input  logic [XLEN-1:0]   exu_fwd_data,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              exu_is_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [4:0]        out_rd,
    output logic              out_r_wen,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef YSYX_24100029_PIPE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            load_use;
    logic            in_fire;
    logic            out_fire;

    ysyx_24100029_fwd_mux #(.W(XLEN)) u_mux1 (
        .choice   (rs1_choice),
        .rf_data  (rf_rs1_data),
        .exu_data (exu_fwd_data),
        .mem_data (mem_fwd_data),
        .src      (src1)
    );

    ysyx_24100029_fwd_mux #(.W(XLEN)) u_mux2 (
        .choice   (rs2_choice),
        .rf_data  (rf_rs2_data),
        .exu_data (exu_fwd_data),
        .mem_data (mem_fwd_data),
        .src      (src2)
    );

    // A load in EXU has no data yet; forwarding from EXU must wait a cycle
    assign load_use = in_valid & exu_is_load &
                      ((rs1_choice == FWD_EXU) | (rs2_choice == FWD_EXU));
    assign in_ready = ~flush & ~load_use & (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_rd    <= '0;
            out_r_wen <= 1'b0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_imm   <= in_imm;
            out_src1  <= src1;
            out_src2  <= src2;
            out_rd    <= in_rd;
            out_r_wen <= in_r_wen;
            out_ctrl  <= in_ctrl;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef YSYX_24100029_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (load_use && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (out_fire && !in_fire && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush && out_valid && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100029_idu_exu_pipe.sv
// Scoreboard bench for the ID->EX pipeline register.
// Directed test-plan cases followed by randomized traffic.
module tb_ysyx_24100029_idu_exu_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_imm, rf1, rf2, exu_d, mem_d;
    logic [4:0]  in_rd;
    logic        in_r_wen;
    logic [15:0] in_ctrl;
    logic [1:0]  c1, c2;
    logic        is_load;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_imm, out_src1, out_src2;
    logic [4:0]  out_rd;
    logic        out_r_wen;
    logic [15:0] out_ctrl;
`ifdef YSYX_24100029_PIPE_PERF_EN
    logic [31:0] p_stall, p_bub, p_fl;
    int          e_stall = 0, e_bub = 0, e_fl = 0;
`endif

    always #5 clk = ~clk;

    ysyx_24100029_idu_exu_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
        .in_r_wen(in_r_wen), .in_ctrl(in_ctrl),
        .rf_rs1_data(rf1), .rf_rs2_data(rf2),
        .rs1_choice(c1), .rs2_choice(c2),
        .exu_fwd_data(exu_d), .mem_fwd_data(mem_d),
        .exu_is_load(is_load),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_rd(out_rd), .out_r_wen(out_r_wen),
        .out_ctrl(out_ctrl)
`ifdef YSYX_24100029_PIPE_PERF_EN
        ,
        .perf_stall_cnt(p_stall),
        .perf_bubble_cnt(p_bub),
        .perf_flush_cnt(p_fl)
`endif
    );

    typedef struct {
        logic [31:0] pc, imm, s1, s2;
        logic [4:0]  rd;
        logic        wen;
        logic [15:0] ctrl;
    } txn_t;

    txn_t q[$];
    int   errs = 0;
    int   checks = 0;
    bit   mv = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] ch,
        input logic [31:0] r, input logic [31:0] e, input logic [31:0] m);
        if (ch == 2'b01) return e;
        if (ch == 2'b10) return m;
        return r;
    endfunction

    // One cycle: inputs already driven; check and predict at negedge
    task automatic step();
        bit lu, er, fire;
        txn_t t;
        @(negedge clk);
        lu = in_valid && is_load && (c1 == 2'b01 || c2 == 2'b01);
        er = !flush && !lu && (!mv || out_ready);
        fire = in_valid && er;
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        if (fire) begin
            t.pc = in_pc; t.imm = in_imm; t.rd = in_rd;
            t.wen = in_r_wen; t.ctrl = in_ctrl;
            t.s1 = pick(c1, rf1, exu_d, mem_d);
            t.s2 = pick(c2, rf2, exu_d, mem_d);
            q.push_back(t);
        end
`ifdef YSYX_24100029_PIPE_PERF_EN
        if (lu) e_stall++;
        if (mv && out_ready && !fire) e_bub++;
        if (flush && mv) e_fl++;
`endif
        if (flush) mv = 0;
        else if (fire) mv = 1;
        else if (mv && out_ready) mv = 0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the held instruction must match the scoreboard front
    initial begin
        txn_t f;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL unexpected_out: pc %h with empty queue",
                             out_pc);
                end else begin
                    f = q[0];
                    chk("out_pc", out_pc, f.pc);
                    chk("out_imm", out_imm, f.imm);
                    chk("out_src1", out_src1, f.s1);
                    chk("out_src2", out_src2, f.s2);
                    chk("out_rd", {27'd0, out_rd}, {27'd0, f.rd});
                    chk("out_wen", {31'd0, out_r_wen}, {31'd0, f.wen});
                    chk("out_ctrl", {16'd0, out_ctrl}, {16'd0, f.ctrl});
                    if (out_ready || flush) void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle();
        flush = 0; in_valid = 0; c1 = 0; c2 = 0; is_load = 0;
        out_ready = 1;
    endtask

    task automatic instr(input logic [31:0] pc);
        in_valid = 1; in_pc = pc; in_imm = pc ^ 32'h5a5a_0000;
        in_rd = pc[6:2]; in_r_wen = pc[2]; in_ctrl = pc[17:2];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_imm"}, out_imm, 32'd0);
        chk({tag, "_src1"}, out_src1, 32'd0);
        chk({tag, "_src2"}, out_src2, 32'd0);
        chk({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_wen"}, {31'd0, out_r_wen}, 32'd0);
        chk({tag, "_ctrl"}, {16'd0, out_ctrl}, 32'd0);
`ifdef YSYX_24100029_PIPE_PERF_EN
        chk({tag, "_pstall"}, p_stall, 32'd0);
        chk({tag, "_pbub"}, p_bub, 32'd0);
        chk({tag, "_pflush"}, p_fl, 32'd0);
        e_stall = 0; e_bub = 0; e_fl = 0;
`endif
    endtask

    initial begin
        rst = 1; idle();
        in_pc = 0; in_imm = 0; in_rd = 0; in_r_wen = 0; in_ctrl = 0;
        rf1 = 0; rf2 = 0; exu_d = 0; mem_d = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // back-to-back from the register file
        rf1 = 32'h11; rf2 = 32'h22;
        for (int i = 0; i < 4; i++) begin
            instr(32'h8000_0000 + 32'(i * 4));
            step();
        end

        // EXU and MEM forwarding
        instr(32'h8000_0100);
        c1 = 2'b01; exu_d = 32'hDEAD; c2 = 2'b10; mem_d = 32'hBEEF;
        step();
        c1 = 2'b11; c2 = 2'b11; instr(32'h8000_0104);
        step();

        // load-use: one bubble then capture from MEM
        instr(32'h8000_0200);
        c1 = 2'b01; c2 = 2'b00; is_load = 1;
        step();
        c1 = 2'b10; is_load = 0; mem_d = 32'h1234;
        step();
        idle();
        step();

        // backpressure on a held instruction
        instr(32'h8000_0004); rf1 = 32'h77;
        step();
        instr(32'h8000_0008); out_ready = 0;
        repeat (3) step();
        out_ready = 1;
        repeat (2) step();

        // flush with held and incoming instruction
        instr(32'h8000_0300); out_ready = 0;
        step();
        instr(32'h8000_0304); flush = 1;
        step();
        flush = 0; out_ready = 1; instr(32'h8000_0308);
        repeat (2) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            instr($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            rf1 = $urandom; rf2 = $urandom;
            exu_d = $urandom; mem_d = $urandom;
            c1 = 2'($urandom_range(0, 3));
            c2 = 2'($urandom_range(0, 3));
            is_load = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

`ifdef YSYX_24100029_PIPE_PERF_EN
        chk("perf_stall", p_stall, 32'(e_stall));
        chk("perf_bubble", p_bub, 32'(e_bub));
        chk("perf_flush", p_fl, 32'(e_fl));
`endif

        // reset while holding under backpressure
        idle(); instr(32'h8000_0400);
        step();
        in_valid = 0; out_ready = 0;
        step();
        rst = 1;
        @(posedge clk);
        #1;
        q.delete();
        mv = 0;
        check_zero("midrst");
        rst = 0; idle();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100029_idu_exu_pipe.md
# ysyx_24100029_idu_exu_pipe

ID→EX pipeline register stage. It consumes the per-operand forwarding select codes produced by the data-hazard unit, resolves each source operand from the register file, the EXU result or the MEM result, and registers the decoded instruction for the EXU under a valid/ready handshake. It also detects load-use hazards, which forwarding cannot cover, and handles them by stalling the IDU and presenting a bubble. Pipeline flush from branch/exception redirect is handled here.

## Interface
- XLEN, 32: datapath width
- CTRL_W, 16: opaque EXU control-bundle width, passed through unmodified
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  redirect; discard held and incoming instruction
- in_valid  in  1  IDU has a decoded instruction
- in_ready  out  1  stage accepts the IDU instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  decoded immediate
- in_rd  in  5  destination register
- in_r_wen  in  1  instruction writes rd
- in_ctrl  in  CTRL_W  EXU control bundle
- rf_rs1_data / rf_rs2_data  in  XLEN  register-file read data
- rs1_choice / rs2_choice  in  2  forwarding select: 00 = RF, 01 = EXU, 10 = MEM, 11 = reserved (treated as 00)
- exu_fwd_data  in  XLEN  EXU result this cycle
- mem_fwd_data  in  XLEN  MEM result this cycle
- exu_is_load  in  1  instruction currently in EXU is a load; its exu_fwd_data is not yet valid
- out_valid  out  1  registered instruction valid to EXU
- out_ready  in  1  EXU accepts
- out_pc, out_imm, out_src1, out_src2  out  XLEN  registered fields / resolved operands
- out_rd  out  5; out_r_wen  out  1; out_ctrl  out  CTRL_W  registered fields

## Operation
- Operand mux: src = choice 01 ? exu_fwd_data : choice 10 ? mem_fwd_data : rf data. The mux is combinational and its result is sampled only on capture.
- load_use = in_valid & exu_is_load & (rs1_choice==01 | rs2_choice==01).
- out_fire = out_valid & out_ready. in_fire = in_valid & in_ready.
- in_ready = ~flush & ~load_use & (~out_valid | out_ready).
- Priority per cycle:
  - flush: out_valid←0. No capture.
  - in_fire: capture all fields and resolved operands. out_valid←1.
  - out_fire without capture: out_valid←0. This is the bubble during load_use.
  - otherwise: hold all registers.
- Data registers are written only on capture. While out_valid=1 and out_ready=0, all out_* stay stable.
- Load-use resolves naturally: next cycle the load is in MEM, so the choice becomes 10 and capture proceeds.

## Timing
- Latency 1 cycle: IDU instruction captured at edge N appears on out_* after edge N.
- Full throughput (1 instr/cycle) when out_ready=1 and no load_use.
- Load-use costs exactly 1 bubble cycle when EXU advances every cycle.
- Reset: out_valid=0. out_pc/out_imm/out_src1/out_src2=0, out_rd=0, out_r_wen=0, out_ctrl=0.
- in_ready is combinational from flush, load_use, out_valid and out_ready. It is 1 after reset, absent flush and load_use.
- Reset asserted mid-stall or with a held instruction: the instruction is dropped and all outputs return to reset values on the next edge.
- flush together with in_valid: the input is not accepted (in_ready=0). Upstream is flushed by the same signal.
- flush together with out_ready while out_valid=1: the held instruction counts as consumed by EXU. EXU must gate on its own flush.

## Configuration
- YSYX_24100029_PIPE_PERF_EN defined: adds 32-bit saturating counters and their outputs:
  - perf_stall_cnt: cycles with load_use=1
  - perf_bubble_cnt: cycles where out_fire occurs without capture
  - perf_flush_cnt: cycles with flush while out_valid=1
  - All counters are cleared by rst.
- Undefined: no counters and no perf ports. Functional behaviour is identical.

## Structure
- Shared package ysyx_24100029_pkg holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_EXU=2'b01, FWD_MEM=2'b10
  - XLEN default
- One sub-module: ysyx_24100029_fwd_mux, the combinational 3-way operand select, instantiated twice.

## Test plan
- Back-to-back, out_ready=1, choice 00, rf_rs1=0x11, rf_rs2=0x22 → out_src1=0x11 and out_src2=0x22 on the following cycle; one instruction per cycle.
- rs1_choice=01, exu_fwd_data=0xDEAD, exu_is_load=0 → out_src1=0xDEAD. rs2_choice=10, mem_fwd_data=0xBEEF → out_src2=0xBEEF.
- Load-use:
  - Cycle 0: rs1_choice=01, exu_is_load=1 → in_ready=0, one bubble (out_valid=0).
  - Cycle 1: choice=10, mem_fwd_data=0x1234 → captured, out_src1=0x1234.
- Backpressure: out_ready=0 for 3 cycles with a held instruction (pc=0x80000004) → in_ready=0 and out_* unchanged. Release → accept resumes.
- flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle, input not captured. Then normal flow.
- rst asserted while holding an instruction mid-backpressure → next edge all outputs zero. With PERF_EN, all counters read 0.
